// File: rtl/dsp_frame_fifo.sv
// Circular sample FIFO with frame-level occupancy flag, interleaved channel tagging,
// a free-running sample-rate tick and optional tick-paced reads.
module dsp_frame_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int CHANNELS  = 2,
  parameter int FRAME_LEN = 128,
  parameter int RATE_DIV  = 50,
  parameter int PACED     = 1,
  localparam int AW       = $clog2(DEPTH),
  localparam int CNT_W    = AW + 1,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CW-1:0]     rd_ch,
  output logic              empty,
  output logic              full,
  output logic              frame_ready,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow,
  output logic              sample_tick
);
  localparam int TW = $clog2(RATE_DIV);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, empty_d, full_q, full_d, frame_ready_q, frame_ready_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [CW-1:0]     rd_ch_q, rd_ch_d, ch_cnt_q, ch_cnt_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic              sample_tick_q, sample_tick_d;
  logic              rd_hon, pop, push;

  always_comb begin
    rd_hon   = rd_en && ((PACED == 0) || sample_tick_q);
    pop      = rd_hon && !empty_q;
    // A full FIFO still pops; the concurrent write is the one that is dropped.
    push     = wr_en && !full_q;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    empty_d       = (count_d == '0);
    full_d        = (count_d == CNT_W'(DEPTH));
    frame_ready_d = (count_d >= CNT_W'(FRAME_LEN));

    rd_valid_d = pop;
    rd_data_d  = pop ? mem_q[rd_ptr_q] : rd_data_q;
    rd_ch_d    = pop ? ch_cnt_q : rd_ch_q;
    ch_cnt_d   = ch_cnt_q;
    if (pop) ch_cnt_d = (ch_cnt_q == CW'(CHANNELS - 1)) ? '0 : ch_cnt_q + CW'(1);

    // A fresh error in the same cycle as clr_err wins.
    overflow_d  = (overflow_q  && !clr_err) || (wr_en  && full_q);
    underflow_d = (underflow_q && !clr_err) || (rd_hon && empty_q);

    sample_tick_d = (tick_cnt_q == TW'(RATE_DIV - 1));
    tick_cnt_d    = sample_tick_d ? '0 : tick_cnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      frame_ready_q <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_ch_q       <= '0;
      ch_cnt_q      <= '0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      tick_cnt_q    <= '0;
      sample_tick_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      frame_ready_q <= frame_ready_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      rd_ch_q       <= rd_ch_d;
      ch_cnt_q      <= ch_cnt_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      tick_cnt_q    <= tick_cnt_d;
      sample_tick_q <= sample_tick_d;
    end
  end

  // Storage needs no reset: pointers define what is live.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_ch       = rd_ch_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign frame_ready = frame_ready_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign sample_tick = sample_tick_q;
endmodule

// File: tb/tb_dsp_frame_fifo.sv
// Directed bench: u0 defaults unpaced, u1 DEPTH=4 paced at RATE_DIV=4, u2 defaults paced.
module tb_dsp_frame_fifo;
  logic        clk = 1'b0;
  logic        reset, wr_en, rd_en, clr_err;
  logic [31:0] wr_data;

  logic [31:0] rd_data0, rd_data1, rd_data2;
  logic        rd_valid0, rd_valid1, rd_valid2;
  logic        rd_ch0, rd_ch1, rd_ch2;
  logic        empty0, empty1, empty2, full0, full1, full2;
  logic        fr0, fr1, fr2, ovf0, ovf1, ovf2, udf0, udf1, udf2;
  logic        tk0, tk1, tk2;
  logic [8:0]  count0, count2;
  logic [2:0]  count1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_frame_fifo #(.PACED(0)) u0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_ch(rd_ch0),
    .empty(empty0), .full(full0), .frame_ready(fr0), .count(count0),
    .overflow(ovf0), .underflow(udf0), .sample_tick(tk0));

  dsp_frame_fifo #(.DEPTH(4), .FRAME_LEN(2), .RATE_DIV(4), .PACED(1)) u1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_ch(rd_ch1),
    .empty(empty1), .full(full1), .frame_ready(fr1), .count(count1),
    .overflow(ovf1), .underflow(udf1), .sample_tick(tk1));

  dsp_frame_fifo u2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(rd_data2), .rd_valid(rd_valid2), .rd_ch(rd_ch2),
    .empty(empty2), .full(full2), .frame_ready(fr2), .count(count2),
    .overflow(ovf2), .underflow(udf2), .sample_tick(tk2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    int first_v, n_v, last_v, found;
    logic [31:0] exp_d [3];

    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
    step(); step();
    chk("rst_count", count0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_full", full0, 0);
    chk("rst_frame_ready", fr0, 0);
    chk("rst_rd_valid", rd_valid0, 0);
    chk("rst_rd_data", rd_data0, 0);
    chk("rst_rd_ch", rd_ch0, 0);
    chk("rst_overflow", ovf0, 0);
    chk("rst_underflow", udf0, 0);
    chk("rst_tick", tk2, 0);
    reset = 1'b0;
    // First tick arrives RATE_DIV cycles after reset release.
    for (int i = 0; i < 49; i++) step();
    chk("tick_before_first", tk2, 0);
    step();
    chk("tick_first", tk2, 1);
    step();
    chk("tick_one_cycle", tk2, 0);

    // Frame fill and drain, unpaced, two channels.
    do_reset();
    wr_en = 1'b1;
    for (int i = 1; i <= 127; i++) begin wr_data = i; step(); end
    chk("fr_before_128", fr0, 0);
    wr_data = 128; step();
    wr_en = 1'b0;
    chk("fr_after_128", fr0, 1);
    chk("count_128", count0, 128);
    chk("not_full_128", full0, 0);
    rd_en = 1'b1;
    for (int i = 1; i <= 128; i++) begin
      step();
      chk("drain_valid", rd_valid0, 1);
      chk("drain_data", rd_data0, i);
      chk("drain_ch", rd_ch0, (i - 1) % 2);
    end
    rd_en = 1'b0;
    chk("drain_empty", empty0, 1);
    chk("drain_count", count0, 0);
    step();
    chk("drain_valid_off", rd_valid0, 0);
    chk("drain_data_hold", rd_data0, 128);

    // Underflow and write-while-empty without bypass.
    do_reset();
    rd_en = 1'b1; step();
    chk("udf_set", udf0, 1);
    chk("udf_no_valid", rd_valid0, 0);
    rd_en = 1'b0; clr_err = 1'b1; step();
    clr_err = 1'b0;
    chk("udf_clr", udf0, 0);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h55; step();
    wr_en = 1'b0;
    chk("wr_rd_empty_count", count0, 1);
    chk("wr_rd_empty_udf", udf0, 1);
    chk("wr_rd_empty_valid", rd_valid0, 0);
    step();
    rd_en = 1'b0;
    chk("nobypass_valid", rd_valid0, 1);
    chk("nobypass_data", rd_data0, 32'h55);
    chk("nobypass_empty", empty0, 1);

    // DEPTH=4: fill, overflow, full with read on and off a tick.
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 10 + i; step();
      if (i == 1) chk("d4_frame_ready", fr1, 1);
      if (i == 2) chk("d4_not_full_3", full1, 0);
    end
    chk("d4_full", full1, 1);
    chk("d4_count4", count1, 4);
    wr_data = 14; step();
    wr_en = 1'b0;
    chk("d4_ovf", ovf1, 1);
    chk("d4_count_hold", count1, 4);
    clr_err = 1'b1; step();
    clr_err = 1'b0;
    chk("d4_ovf_clr", ovf1, 0);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) if (tk1 == 1'b0) found = 1; else step();
    chk("d4_find_notick", found, 1);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 99; step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("full_wr_rd_count", count1, 4);
    chk("full_wr_rd_ovf", ovf1, 1);
    chk("full_wr_rd_novalid", rd_valid1, 0);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) if (tk1 == 1'b1) found = 1; else step();
    chk("d4_find_tick", found, 1);
    clr_err = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 77; step();
    clr_err = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("full_pop_count", count1, 3);
    chk("full_pop_valid", rd_valid1, 1);
    chk("full_pop_data", rd_data1, 10);
    chk("ovf_priority", ovf1, 1);
    chk("full_pop_not_full", full1, 0);
    wr_en = 1'b1; wr_data = 20; step();
    wr_en = 1'b0; rd_en = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      step();
      if (rd_valid1) found = 1;
    end
    rd_en = 1'b0;
    chk("d4_next_found", found, 1);
    chk("d4_next_data", rd_data1, 11);
    chk("d4_next_ch", rd_ch1, 1);

    // Paced reads: one pop per tick with rd_en held high.
    do_reset();
    wr_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin wr_data = i; step(); end
    wr_en = 1'b0; rd_en = 1'b1;
    exp_d[0] = 1; exp_d[1] = 2; exp_d[2] = 3;
    n_v = 0; first_v = 0; last_v = 0;
    for (int e = 4; e <= 180; e++) begin
      step();
      if (rd_valid2) begin
        if (n_v == 0) first_v = e;
        else chk("paced_spacing", e - last_v, 50);
        if (n_v < 3) chk("paced_data", rd_data2, exp_d[n_v]);
        last_v = e;
        n_v++;
      end
    end
    rd_en = 1'b0;
    chk("paced_pops", n_v, 3);
    chk("paced_first", first_v, 51);
    chk("paced_empty", empty2, 1);

    // Reset mid-operation with requests asserted.
    do_reset();
    wr_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin wr_data = i; step(); end
    chk("pre_rst_count", count0, 10);
    for (int i = 0; i < 20; i++) step();
    reset = 1'b1; rd_en = 1'b1; step();
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("mid_rst_count", count0, 0);
    chk("mid_rst_empty", empty0, 1);
    chk("mid_rst_valid", rd_valid0, 0);
    chk("mid_rst_count_u2", count2, 0);
    for (int i = 0; i < 49; i++) step();
    chk("mid_rst_tick_before", tk2, 0);
    step();
    chk("mid_rst_tick_restart", tk2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dsp_frame_fifo.md
DSP_FRAME_FIFO -- requirements
Module: dsp_frame_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, entry count; power of two, minimum 4.
REQ-003 SHALL have parameter CHANNELS, default 2, interleaved channels per frame slot (1..8).
REQ-004 SHALL have parameter FRAME_LEN, default 128, entries that make a frame; range 1..DEPTH.
REQ-005 SHALL have parameter RATE_DIV, default 50, clk cycles per sample tick; minimum 2.
REQ-006 SHALL have parameter PACED, default 1; 1 = reads honoured only on tick cycles, 0 = reads honoured any cycle.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port wr_en, input, 1, write request.
REQ-010 SHALL have port wr_data, input, DATA_W, sample to store.
REQ-011 SHALL have port rd_en, input, 1, read request.
REQ-012 SHALL have port clr_err, input, 1, clears sticky error flags.
REQ-013 SHALL have port rd_data, output, DATA_W, registered read sample.
REQ-014 SHALL have port rd_valid, output, 1, rd_data is valid this cycle.
REQ-015 SHALL have port rd_ch, output, clog2(CHANNELS) (min 1), channel index of rd_data.
REQ-016 SHALL have ports empty, full, frame_ready, each output, 1, occupancy flags.
REQ-017 SHALL have port count, output, clog2(DEPTH)+1, current occupancy.
REQ-018 SHALL have ports overflow, underflow, each output, 1, sticky error flags.
REQ-019 SHALL have port sample_tick, output, 1, one-cycle pulse every RATE_DIV cycles.

Function
REQ-020 SHALL implement a circular buffer with wr_ptr and rd_ptr wrapping from DEPTH-1 to 0.
REQ-021 SHALL accept a write when wr_en=1 and full=0; a write with full=1 SHALL be dropped and SHALL set overflow.
REQ-022 SHALL define read-honoured as rd_en=1 and (PACED=0 or sample_tick=1).
REQ-023 SHALL pop when read-honoured and empty=0, presenting the entry on rd_data with rd_valid=1 exactly one cycle later.
REQ-024 SHALL set underflow when read-honoured while empty=1, with no pop and rd_valid=0 on the following cycle.
REQ-025 SHALL hold rd_data at its last value when rd_valid=0.
REQ-026 SHALL, on a simultaneous accepted write and pop, leave count unchanged; when full=1, the pop SHALL proceed and the write SHALL be dropped.
REQ-027 SHALL, on a simultaneous write and pop while empty=1, accept the write and flag underflow; data is not bypassed.
REQ-028 SHALL keep count, empty (count=0), full (count=DEPTH) and frame_ready (count>=FRAME_LEN) registered and consistent in the same cycle.
REQ-029 SHALL maintain a read-channel counter that increments on each pop and wraps from CHANNELS-1 to 0; rd_ch SHALL equal its value for the popped entry.
REQ-030 SHALL generate sample_tick from a counter 0..RATE_DIV-1 that pulses when the counter equals RATE_DIV-1; the counter SHALL free-run regardless of FIFO state.
REQ-031 SHALL clear overflow and underflow on clr_err=1; a new error in the same cycle SHALL take priority and leave the flag set.

Reset
REQ-032 SHALL, while reset=1, clear pointers, channel counter and tick counter, and drive count=0, empty=1, full=0, frame_ready=0, rd_valid=0, rd_ch=0, rd_data=0, overflow=0, underflow=0, sample_tick=0.
REQ-033 SHALL discard all stored contents and ignore wr_en and rd_en in any cycle with reset=1, including reset asserted mid-operation.
REQ-034 SHALL assert the first sample_tick RATE_DIV cycles after the first cycle with reset=0.

Verification
REQ-035 Defaults, PACED=0: write 128 samples 1..128 -> frame_ready rises on the cycle after the 128th write, count=128; read all -> rd_data 1..128 in order, rd_ch alternating 0,1, empty=1 at the end.
REQ-036 DEPTH=4: write 5 samples -> full=1 after the 4th, 5th dropped, overflow=1; clr_err -> overflow=0.
REQ-037 Read on empty -> underflow=1, rd_valid=0; simultaneous write and read on empty -> count=1, underflow=1.
REQ-038 PACED=1, RATE_DIV=50, rd_en held high, FIFO preloaded with 3 samples -> exactly one pop per tick, rd_valid spaced 50 cycles apart.
REQ-039 Full FIFO, simultaneous wr_en and rd_en -> count remains DEPTH, written sample dropped, overflow=1.
REQ-040 Reset asserted with count=10 -> next cycle count=0, empty=1, rd_valid=0, tick counter restarted.
